// File: rtl/pcileech_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcileech_cfg_pkg: shared FSM states, TLP constants and the           |
// | completion header builder for the config completion generator.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pcileech_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_SEND = 3'd4
  } cfg_state_e;

  localparam logic [2:0]  FMT_CPL        = 3'b000;
  localparam logic [2:0]  FMT_CPLD       = 3'b010;
  localparam logic [4:0]  TYPE_CPL       = 5'b01010;
  localparam logic [2:0]  CPL_SC         = 3'b000;
  localparam logic [2:0]  CPL_UR         = 3'b001;
  localparam logic [11:0] CPL_BYTE_COUNT = 12'd4;

  // Returns {DW2, DW1, DW0} of a 3DW completion header.
  function automatic logic [95:0] build_cpl_hdr(
    input logic        cpld,
    input logic [2:0]  status,
    input logic [15:0] cpl_id,
    input logic [2:0]  tc,
    input logic [1:0]  attr,
    input logic [15:0] rid,
    input logic [7:0]  tag
  );
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    dw0 = {(cpld ? FMT_CPLD : FMT_CPL), TYPE_CPL, 1'b0, tc, 4'b0000, 2'b00,
           attr, 2'b00, {9'd0, cpld}};
    dw1 = {cpl_id, status, 1'b0, CPL_BYTE_COUNT};
    dw2 = {rid, tag, 1'b0, 7'd0};
    return {dw2, dw1, dw0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_tlps128_cfg_cpl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcileech_tlps128_cfg_cpl_gen: services one CfgRd0/CfgWr0 at a time   |
// | on the config shadow store and emits a single-beat Cpl/CplD TLP.     |
// | Optional PCILEECH_CFG_CPL_STATS_EN adds completion/UR counters.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pcileech_tlps128_cfg_cpl_gen
  import pcileech_cfg_pkg::*;
#(
  parameter int unsigned FUNC_COUNT = 3,
  parameter logic [9:0]  REG_DW_MAX = 10'h3FF
) (
  input  logic         clk_pcie,
  input  logic         rst_n,
  input  logic [15:0]  pcie_id,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_func,
  input  logic [9:0]   req_reg,
  input  logic [3:0]   req_be,
  input  logic [31:0]  req_wdata,
  input  logic [15:0]  req_rid,
  input  logic [7:0]   req_tag,
  input  logic [2:0]   req_tc,
  input  logic [1:0]   req_attr,
  output logic         sh_rd_en,
  output logic         sh_wr_en,
  output logic [2:0]   sh_func,
  output logic [9:0]   sh_addr,
  output logic [3:0]   sh_be,
  output logic [31:0]  sh_wdata,
  input  logic [31:0]  sh_rdata,
  output logic [127:0] tlp_tdata,
  output logic [3:0]   tlp_tkeepdw,
  output logic         tlp_tvalid,
  input  logic         tlp_tready,
  output logic         tlp_tfirst,
  output logic         tlp_tlast
`ifdef PCILEECH_CFG_CPL_STATS_EN
  ,
  output logic [15:0]  cnt_cpl,
  output logic [15:0]  cnt_ur
`endif
);

  cfg_state_e  state_q, state_d;
  logic        write_q, ur_q, oor_q;
  logic [2:0]  func_q, tc_q;
  logic [9:0]  reg_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q, rdata_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [1:0]  attr_q;

  logic        accept, req_ur, req_oor, cpld;
  logic [95:0] hdr;
  logic        unused_pcie_func;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_ur  = 32'(req_func) >= FUNC_COUNT;
  assign req_oor = {1'b0, req_reg} > {1'b0, REG_DW_MAX};

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    sh_rd_en   = 1'b0;
    sh_wr_en   = 1'b0;
    tlp_tvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_ur || req_oor) state_d = ST_SEND;
          else if (req_write)    state_d = ST_WR;
          else                   state_d = ST_RD;
        end
      end
      ST_RD: begin
        sh_rd_en = 1'b1;
        state_d  = ST_RDW;
      end
      ST_RDW: state_d = ST_SEND;
      ST_WR: begin
        sh_wr_en = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        tlp_tvalid = 1'b1;
        if (tlp_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata_q is cleared on accept so non-read completions carry a zero DW3.
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      ur_q    <= 1'b0;
      oor_q   <= 1'b0;
      func_q  <= '0;
      reg_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rid_q   <= '0;
      tag_q   <= '0;
      tc_q    <= '0;
      attr_q  <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      ur_q    <= req_ur;
      oor_q   <= req_oor;
      func_q  <= req_func;
      reg_q   <= req_reg;
      be_q    <= req_be;
      wdata_q <= req_wdata;
      rid_q   <= req_rid;
      tag_q   <= req_tag;
      tc_q    <= req_tc;
      attr_q  <= req_attr;
      rdata_q <= '0;
    end else if (state_q == ST_RDW && !oor_q) begin
      rdata_q <= sh_rdata;
    end
  end

  assign sh_func  = func_q;
  assign sh_addr  = reg_q;
  assign sh_be    = be_q;
  assign sh_wdata = wdata_q;

  assign cpld = !write_q && !ur_q;
  assign hdr  = build_cpl_hdr(cpld, (ur_q ? CPL_UR : CPL_SC), {pcie_id[15:3], func_q},
                              tc_q, attr_q, rid_q, tag_q);

  assign tlp_tdata   = tlp_tvalid ? {rdata_q, hdr} : '0;
  assign tlp_tkeepdw = tlp_tvalid ? (cpld ? 4'b1111 : 4'b0111) : 4'b0000;
  assign tlp_tfirst  = 1'b1;
  assign tlp_tlast   = 1'b1;

  // The completer ID substitutes the request's function number.
  assign unused_pcie_func = ^pcie_id[2:0];

`ifdef PCILEECH_CFG_CPL_STATS_EN
  logic [15:0] cnt_cpl_q, cnt_ur_q;

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cpl_q <= '0;
      cnt_ur_q  <= '0;
    end else if (tlp_tvalid && tlp_tready) begin
      cnt_cpl_q <= cnt_cpl_q + 16'd1;
      if (ur_q) cnt_ur_q <= cnt_ur_q + 16'd1;
    end
  end

  assign cnt_cpl = cnt_cpl_q;
  assign cnt_ur  = cnt_ur_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlps128_cfg_cpl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pcileech_tlps128_cfg_cpl_gen: scoreboard bench for the config     |
// | completion generator with a behavioural shadow store.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pcileech_tlps128_cfg_cpl_gen;

  localparam int unsigned FUNCS   = 3;
  localparam logic [9:0]  REG_MAX = 10'h1FF;

  logic         clk_pcie = 1'b0;
  logic         rst_n;
  logic [15:0]  pcie_id;
  logic         req_valid, req_ready, req_write;
  logic [2:0]   req_func, req_tc;
  logic [9:0]   req_reg;
  logic [3:0]   req_be;
  logic [31:0]  req_wdata;
  logic [15:0]  req_rid;
  logic [7:0]   req_tag;
  logic [1:0]   req_attr;
  logic         sh_rd_en, sh_wr_en;
  logic [2:0]   sh_func;
  logic [9:0]   sh_addr;
  logic [3:0]   sh_be;
  logic [31:0]  sh_wdata;
  logic [31:0]  sh_rdata = 32'h0;
  logic [127:0] tlp_tdata;
  logic [3:0]   tlp_tkeepdw;
  logic         tlp_tvalid, tlp_tready, tlp_tfirst, tlp_tlast;
`ifdef PCILEECH_CFG_CPL_STATS_EN
  logic [15:0]  cnt_cpl, cnt_ur;
`endif

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, hs_cnt = 0, tv_cnt = 0;
  logic [2:0]  wr_func = '0;
  logic [9:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [131:0] exp_q[$];

  always #5 clk_pcie = ~clk_pcie;

  pcileech_tlps128_cfg_cpl_gen #(.FUNC_COUNT(FUNCS), .REG_DW_MAX(REG_MAX)) dut (
    .clk_pcie(clk_pcie), .rst_n(rst_n), .pcie_id(pcie_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_func(req_func), .req_reg(req_reg), .req_be(req_be), .req_wdata(req_wdata),
    .req_rid(req_rid), .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
    .sh_rd_en(sh_rd_en), .sh_wr_en(sh_wr_en), .sh_func(sh_func), .sh_addr(sh_addr),
    .sh_be(sh_be), .sh_wdata(sh_wdata), .sh_rdata(sh_rdata),
    .tlp_tdata(tlp_tdata), .tlp_tkeepdw(tlp_tkeepdw), .tlp_tvalid(tlp_tvalid),
    .tlp_tready(tlp_tready), .tlp_tfirst(tlp_tfirst), .tlp_tlast(tlp_tlast)
`ifdef PCILEECH_CFG_CPL_STATS_EN
    , .cnt_cpl(cnt_cpl), .cnt_ur(cnt_ur)
`endif
  );

  function automatic logic [31:0] shpat(input logic [2:0] f, input logic [9:0] a);
    if (f == 3'd0 && a == 10'd0) return 32'h9A0B8086;
    return {5'h15, f, 14'h2A5, a};
  endfunction

  // Shadow store: read data valid only in the cycle after the strobe.
  always @(posedge clk_pcie) begin
    sh_rdata <= sh_rd_en ? shpat(sh_func, sh_addr) : 32'hDEADBEEF;
    if (sh_rd_en) rd_cnt <= rd_cnt + 1;
    if (sh_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_func <= sh_func;
      wr_addr <= sh_addr;
      wr_be   <= sh_be;
      wr_data <= sh_wdata;
    end
    if (tlp_tvalid && tlp_tready) hs_cnt <= hs_cnt + 1;
    if (tlp_tvalid) tv_cnt <= tv_cnt + 1;
  end

  function automatic logic [131:0] exp_tlp(input logic wr, input logic [2:0] f,
      input logic [9:0] r, input logic [15:0] pid, input logic [15:0] rid,
      input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr);
    logic ur, oor, cd;
    logic [31:0] d0, d1, d2, d3;
    ur  = f >= 3'(FUNCS);
    oor = r > REG_MAX;
    cd  = !wr && !ur;
    d0  = {(cd ? 3'b010 : 3'b000), 5'b01010, 1'b0, tc, 6'b000000, attr, 2'b00,
           (cd ? 10'd1 : 10'd0)};
    d1  = {pid[15:3], f, (ur ? 3'b001 : 3'b000), 1'b0, 12'd4};
    d2  = {rid, tag, 8'h00};
    d3  = (cd && !oor) ? shpat(f, r) : 32'h0;
    return {(cd ? 4'hF : 4'h7), d3, d2, d1, d0};
  endfunction

  task automatic run_req(input logic wr, input logic [2:0] f, input logic [9:0] r,
      input logic [3:0] be, input logic [31:0] wd, input logic [15:0] rid,
      input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr, input int stall);
    int lat, rd0, wr0, hs0, exp_lat, exp_rd, exp_wr;
    logic ur, oor, seen;
    logic [131:0] ev;
    ur      = f >= 3'(FUNCS);
    oor     = r > REG_MAX;
    exp_lat = (ur || oor) ? 1 : (wr ? 2 : 3);
    exp_rd  = (!wr && !ur && !oor) ? 1 : 0;
    exp_wr  = (wr && !ur && !oor) ? 1 : 0;
    exp_q.push_back(exp_tlp(wr, f, r, pcie_id, rid, tag, tc, attr));
    tlp_tready = 1'b0;
    @(negedge clk_pcie);
    rd0 = rd_cnt; wr0 = wr_cnt; hs0 = hs_cnt;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_idle: got %b need 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_func = f; req_reg = r; req_be = be;
    req_wdata = wd; req_rid = rid; req_tag = tag; req_tc = tc; req_attr = attr;
    @(posedge clk_pcie); #1 req_valid = 1'b0;
    lat = 0; seen = 1'b0;
    repeat (20) if (!seen) begin
      lat++;
      @(negedge clk_pcie);
      if (tlp_tvalid === 1'b1) seen = 1'b1;
      else @(posedge clk_pcie);
    end
    ev = exp_q.pop_front();
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++; $display("FAIL latency: got %0d (seen=%b) need %0d", lat, seen, exp_lat);
    end
    if (!seen) return;
    checks++;
    if (tlp_tdata !== ev[127:0]) begin
      errors++; $display("FAIL tdata: got %h need %h", tlp_tdata, ev[127:0]);
    end
    checks++;
    if (tlp_tkeepdw !== ev[131:128] || tlp_tfirst !== 1'b1 || tlp_tlast !== 1'b1) begin
      errors++; $display("FAIL keep_first_last: got %h/%b/%b need %h/1/1",
                         tlp_tkeepdw, tlp_tfirst, tlp_tlast, ev[131:128]);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_pcie); @(negedge clk_pcie);
      checks++;
      if (tlp_tvalid !== 1'b1 || tlp_tdata !== ev[127:0] || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold: cyc %0d valid=%b ready=%b data=%h need %h",
                           i, tlp_tvalid, req_ready, tlp_tdata, ev[127:0]);
      end
    end
    tlp_tready = 1'b1;
    @(posedge clk_pcie); #1 tlp_tready = 1'b0;
    @(negedge clk_pcie);
    checks++;
    if (tlp_tvalid !== 1'b0 || req_ready !== 1'b1 || hs_cnt - hs0 != 1) begin
      errors++; $display("FAIL post_handshake: valid=%b ready=%b hs=%0d need 0/1/1",
                         tlp_tvalid, req_ready, hs_cnt - hs0);
    end
    checks++;
    if (rd_cnt - rd0 != exp_rd || wr_cnt - wr0 != exp_wr) begin
      errors++; $display("FAIL strobes: rd=%0d wr=%0d need %0d/%0d",
                         rd_cnt - rd0, wr_cnt - wr0, exp_rd, exp_wr);
    end
    if (exp_wr == 1) begin
      checks++;
      if (wr_func !== f || wr_addr !== r || wr_be !== be || wr_data !== wd) begin
        errors++; $display("FAIL write_args: got %h/%h/%h/%h need %h/%h/%h/%h",
                           wr_func, wr_addr, wr_be, wr_data, f, r, be, wd);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || tlp_tvalid !== 1'b0 || sh_rd_en !== 1'b0 || sh_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b valid=%b rd=%b wr=%b need 1/0/0/0",
                         req_ready, tlp_tvalid, sh_rd_en, sh_wr_en);
    end
    checks++;
    if (tlp_tdata !== 128'h0 || tlp_tkeepdw !== 4'h0 || tlp_tfirst !== 1'b1 || tlp_tlast !== 1'b1) begin
      errors++; $display("FAIL reset_tlp: data=%h keep=%h first=%b last=%b need 0/0/1/1",
                         tlp_tdata, tlp_tkeepdw, tlp_tfirst, tlp_tlast);
    end
    checks++;
    if ({sh_func, sh_addr, sh_be, sh_wdata} !== 49'h0) begin
      errors++; $display("FAIL reset_sh_bus: got %h need 0", {sh_func, sh_addr, sh_be, sh_wdata});
    end
  endtask

  task automatic test_read;
    run_req(1'b0, 3'd0, 10'd0, 4'hF, 32'h0, 16'h0010, 8'h05, 3'd0, 2'd0, 0);
    run_req(1'b0, 3'd2, 10'h1FF, 4'hF, 32'h0, 16'h1234, 8'hA7, 3'd5, 2'd2, 0);
  endtask

  task automatic test_write;
    run_req(1'b1, 3'd1, 10'd4, 4'b0011, 32'hFFFF0000, 16'h0010, 8'h06, 3'd0, 2'd0, 0);
  endtask

  task automatic test_ur;
    run_req(1'b0, 3'd5, 10'd0, 4'hF, 32'h0, 16'h0010, 8'h07, 3'd0, 2'd0, 0);
    run_req(1'b1, 3'd3, 10'd8, 4'hF, 32'h12345678, 16'h0020, 8'h08, 3'd1, 2'd1, 0);
  endtask

  task automatic test_out_of_range;
    run_req(1'b0, 3'd0, 10'h200, 4'hF, 32'h0, 16'h0030, 8'h09, 3'd2, 2'd3, 0);
    run_req(1'b1, 3'd1, 10'h3FF, 4'hF, 32'hCAFEF00D, 16'h0030, 8'h0A, 3'd0, 2'd0, 0);
  endtask

  task automatic test_stall;
    run_req(1'b0, 3'd1, 10'd16, 4'hF, 32'h0, 16'h0040, 8'h0B, 3'd7, 2'd1, 20);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++)
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 10'($urandom_range(0, 1023)),
              4'($urandom), $urandom, 16'($urandom), 8'($urandom), 3'($urandom),
              2'($urandom), int'($urandom_range(0, 2)));
  endtask

  task automatic test_reset_mid;
    int rd0, wr0, tv0;
    tlp_tready = 1'b0;
    @(negedge clk_pcie);
    rd0 = rd_cnt; wr0 = wr_cnt; tv0 = tv_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_func = 3'd0; req_reg = 10'd3;
    @(posedge clk_pcie); #1 req_valid = 1'b0;
    @(posedge clk_pcie); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_pcie);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_pcie);
    checks++;
    if (tv_cnt != tv0 || rd_cnt - rd0 != 1 || wr_cnt != wr0) begin
      errors++; $display("FAIL reset_mid_activity: tv=%0d rd=%0d wr=%0d need 0/1/0",
                         tv_cnt - tv0, rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (req_ready !== 1'b1 || tlp_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle: ready=%b valid=%b need 1/0", req_ready, tlp_tvalid);
    end
  endtask

`ifdef PCILEECH_CFG_CPL_STATS_EN
  task automatic test_stats;
    checks++;
    if (cnt_cpl !== 16'd0 || cnt_ur !== 16'd0) begin
      errors++; $display("FAIL stats_reset: cpl=%0d ur=%0d need 0/0", cnt_cpl, cnt_ur);
    end
    run_req(1'b0, 3'd4, 10'd0, 4'hF, 32'h0, 16'h0050, 8'h10, 3'd0, 2'd0, 0);
    run_req(1'b0, 3'd0, 10'd1, 4'hF, 32'h0, 16'h0050, 8'h11, 3'd0, 2'd0, 0);
    run_req(1'b1, 3'd7, 10'd2, 4'hF, 32'h0, 16'h0050, 8'h12, 3'd0, 2'd0, 0);
    checks++;
    if (cnt_cpl !== 16'd3 || cnt_ur !== 16'd2) begin
      errors++; $display("FAIL stats_count: cpl=%0d ur=%0d need 3/2", cnt_cpl, cnt_ur);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; pcie_id = 16'h0300;
    req_valid = 1'b0; req_write = 1'b0; req_func = '0; req_reg = '0; req_be = '0;
    req_wdata = '0; req_rid = '0; req_tag = '0; req_tc = '0; req_attr = '0;
    tlp_tready = 1'b0;
    repeat (3) @(negedge clk_pcie);
    test_reset();
    rst_n = 1'b1;
    test_read();
    test_write();
    test_ur();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef PCILEECH_CFG_CPL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcileech_tlps128_cfg_cpl_gen.md
# pcileech_tlps128_cfg_cpl_gen

Completion generator for Type 0 configuration requests in the VMD/NVMe multifunction design. It accepts decoded CfgRd0/CfgWr0 requests from the multifunction config-space controller and performs one read or write per request on the config shadow store. It then emits a single-beat 128-bit Cpl/CplD TLP into mux source 0, which carries config responses toward the PCIe core.

## Interface
Parameters:
- FUNC_COUNT, 3, number of implemented functions; a request with req_func >= FUNC_COUNT completes with UR status.
- REG_DW_MAX, 10'h3FF, highest implemented DW register index; a request with a higher req_reg gets a CplD of data 0 (read) or is ignored (write), with SC status.

Ports:
- clk_pcie  in  1  PCIe user clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- pcie_id  in  16  {bus[7:0], dev[4:0], func[2:0]} of the core; completer ID = {pcie_id[15:3], req_func}.
- req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both are high.
- req_write  in  1  1 = CfgWr0, 0 = CfgRd0.
- req_func  in  3  target function.
- req_reg  in  10  DW register index.
- req_be  in  4  first-DW byte enables.
- req_wdata  in  32  write data.
- req_rid  in  16  requester ID.
- req_tag  in  8  tag.
- req_tc  in  3  traffic class.
- req_attr  in  2  attributes.
- sh_rd_en  out  1  shadow read strobe.
- sh_wr_en  out  1  shadow write strobe.
- sh_func  out  3  shadow function select.
- sh_addr  out  10  shadow DW address.
- sh_be  out  4  shadow byte enables.
- sh_wdata  out  32  shadow write data.
- sh_rdata  in  32  shadow read data, valid exactly 1 cycle after sh_rd_en.
- tlp_tdata  out  128  TLP beat; DW0 is in [31:0].
- tlp_tkeepdw  out  4  valid-DW mask.
- tlp_tvalid / tlp_tready  out / in  1 / 1  AXIS handshake.
- tlp_tfirst, tlp_tlast  out  1 each  both high on every beat.

## Operation
- FSM states: IDLE, RD, RDW, WR, SEND.
- IDLE:
  - req_ready = 1.
  - On accept, latch all request fields.
  - Unsupported function -> SEND with UR.
  - Read -> RD; write -> WR.
- RD: assert sh_rd_en for one cycle -> RDW.
- RDW: capture sh_rdata -> SEND.
- WR: assert sh_wr_en for one cycle with sh_be = req_be -> SEND.
- Out-of-range req_reg: no shadow strobe is issued; go straight to SEND.
- SEND:
  - Hold tlp_tvalid and tlp_tdata stable until tlp_tready.
  - On handshake -> IDLE.
- Header DW0:
  - CplD: fmt=3'b010, type=5'b01010, length=1, tkeepdw=4'b1111.
  - Cpl (write or UR): fmt=3'b000, length=0, tkeepdw=4'b0111.
  - TC and attr are echoed from the request.
- Header DW1: {completer ID, status[2:0], BCM=0, byte count=12'd4}.
  - Status is 3'b000 (SC) or 3'b001 (UR).
- Header DW2: {req_rid, req_tag, 1'b0, lower address=7'd0}.
- DW3: captured read data (0 for out-of-range reads); 0 when not a CplD.
- Only one request is outstanding at a time; there is no queueing.

## Timing
- Reset values:
  - FSM = IDLE, req_ready = 1.
  - sh_rd_en = sh_wr_en = 0.
  - tlp_tvalid = 0; tlp_tdata, tlp_tkeepdw and sh_* buses = 0.
  - tlp_tfirst = tlp_tlast = 1 (constant).
- Read latency: accept at cycle N -> sh_rd_en at N+1 -> tlp_tvalid at N+3.
- Write latency: accept at N -> sh_wr_en at N+1 -> tlp_tvalid at N+2.
- UR or out-of-range latency: accept at N -> tlp_tvalid at N+1.
- req_ready is low from the cycle after accept until the cycle after the SEND handshake, so peak throughput is one request per 4 cycles (read, tready high).
- tlp_tready stalls of any length are legal; the output stays frozen.
- rst_n asserted mid-transaction:
  - Immediately abandon the transaction; no partial TLP and no shadow strobe is issued afterwards.
  - A write strobe already issued is not rolled back.

## Configuration
- PCILEECH_CFG_CPL_STATS_EN defined:
  - Adds outputs cnt_cpl[15:0] (SEND handshakes) and cnt_ur[15:0] (UR completions).
  - Both wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package pcileech_cfg_pkg holds:
  - State enum.
  - Fmt/type constants (FMT_CPL, FMT_CPLD, TYPE_CPL).
  - Status constants (CPL_SC, CPL_UR).
  - Function build_cpl_hdr(...) returning 96 bits.
- No sub-module; the header assembly is the package function.

## Test plan
- CfgRd0, func 0, reg 0, shadow returns 32'h9A0B8086, pcie_id 16'h0300, rid 16'h0010, tag 8'h05:
  - CplD with DW0 = 32'h4A000001, DW1 = 32'h03000004, DW2 = 32'h00100500, DW3 = 32'h9A0B8086.
  - tkeepdw = 4'hF; tvalid 3 cycles after accept.
- CfgWr0, func 1, reg 4, be 4'b0011, wdata 32'hFFFF0000:
  - One sh_wr_en pulse with sh_func = 1, sh_addr = 4, sh_be = 4'b0011.
  - Cpl with DW0 = 32'h0A000000 and DW1 status SC; tkeepdw = 4'h7.
- CfgRd0 to func 5:
  - No shadow strobe; Cpl with status 3'b001; tvalid the cycle after accept.
- tlp_tready held low 20 cycles during SEND:
  - tdata stable throughout, req_ready stays 0.
  - Exactly one handshake once tready rises.
- rst_n pulsed low during RDW:
  - tvalid never rises; FSM in IDLE with req_ready = 1 after release.
- With PCILEECH_CFG_CPL_STATS_EN: 65537 completions -> cnt_cpl = 1; 3 UR completions -> cnt_ur = 3.
